// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Sequencing and hazard control for a simple in-order pipeline. An
// IDLE -> WARMUP -> RUN -> HALTED state machine gates the PC and the IF/ID
// register. While in RUN, it resolves the following hazards by priority:
// memory stall, then taken-branch flush, then load-use stall.
// Optional build macro: PIPE_CTRL_PERF_CNT_EN adds the stallCount and
// flushCount performance counters.
// WARMUP_CYCLES must lie in the range 1..7.
module pipeline_hazard_controller #(
   parameter int unsigned WARMUP_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        startProcess,
   input  logic        haltReq,
   input  logic        memBusy,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic        ID_useRs1,
   input  logic        ID_useRs2,
   input  logic [4:0]  EX_rd,
   input  logic        EX_memRead,
   input  logic        EX_branchTaken,
   output logic        pcWrite,
   output logic        harzardIF_ID_Write,
   output logic        IF_flush,
   output logic        ID_EX_bubble,
   output logic        running
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] stallCount,
   output logic [31:0] flushCount
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      RUN    = 2'd2,
      HALTED = 2'd3
   } state_t;

   // Final warmup count value; the counter runs from 0 up to this value.
   localparam logic [2:0] WARM_LAST = 3'(WARMUP_CYCLES - 1);

   state_t      state_reg;
   state_t      state_next;
   logic [2:0]  warm_cnt_reg;
   logic [2:0]  warm_cnt_next;
   logic        load_use;
   logic        rs1_hit;
   logic        rs2_hit;

   // Load-use hazard: the ID instruction reads the register that a load
   // currently in EX has not yet produced. Register x0 is never a hazard.
   always_comb begin
      rs1_hit  = ID_useRs1 && (ID_rs1 == EX_rd);
      rs2_hit  = ID_useRs2 && (ID_rs2 == EX_rd);
      load_use = EX_memRead && (EX_rd != 5'd0) && (rs1_hit || rs2_hit);
   end

   // Register the state and the warmup counter. Reset is asynchronous.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg    <= IDLE;
         warm_cnt_reg <= 3'd0;
      end else begin
         state_reg    <= state_next;
         warm_cnt_reg <= warm_cnt_next;
      end
   end

   // Compute the next state. HALTED is left only through reset.
   always_comb begin
      state_next    = state_reg;
      warm_cnt_next = warm_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (startProcess) begin
               state_next    = WARMUP;
               warm_cnt_next = 3'd0;
            end
         end
         WARMUP: begin
            if (warm_cnt_reg == WARM_LAST) begin
               state_next    = RUN;
               warm_cnt_next = 3'd0;
            end else begin
               warm_cnt_next = warm_cnt_reg + 3'd1;
            end
         end
         RUN: begin
            // A halt that arrives during a memory stall waits until the
            // pipeline is able to move again.
            if (haltReq && !memBusy) begin
               state_next = HALTED;
            end
         end
         HALTED: begin
            state_next = HALTED;
         end
         default: begin
            state_next    = IDLE;
            warm_cnt_next = 3'd0;
         end
      endcase
   end

   // Drive the pipeline control outputs from the state and the hazard
   // inputs. A branch takes priority over a load-use stall, so an
   // instruction on the wrong path is flushed rather than stalled.
   always_comb begin
      pcWrite            = 1'b0;
      harzardIF_ID_Write = 1'b1;
      IF_flush           = 1'b0;
      ID_EX_bubble       = 1'b1;
      running            = 1'b0;
      case (state_reg)
         IDLE, WARMUP: begin
            pcWrite            = 1'b0;
            harzardIF_ID_Write = 1'b1;
            IF_flush           = 1'b0;
            ID_EX_bubble       = 1'b1;
         end
         RUN: begin
            running = 1'b1;
            if (memBusy) begin
               pcWrite            = 1'b0;
               harzardIF_ID_Write = 1'b0;
               IF_flush           = 1'b0;
               ID_EX_bubble       = 1'b0;
            end else if (EX_branchTaken) begin
               pcWrite            = 1'b1;
               harzardIF_ID_Write = 1'b1;
               IF_flush           = 1'b1;
               ID_EX_bubble       = 1'b1;
            end else if (load_use) begin
               pcWrite            = 1'b0;
               harzardIF_ID_Write = 1'b0;
               IF_flush           = 1'b0;
               ID_EX_bubble       = 1'b1;
            end else begin
               pcWrite            = 1'b1;
               harzardIF_ID_Write = 1'b1;
               IF_flush           = 1'b0;
               ID_EX_bubble       = 1'b0;
            end
         end
         HALTED: begin
            pcWrite            = 1'b0;
            harzardIF_ID_Write = 1'b0;
            IF_flush           = 1'b0;
            ID_EX_bubble       = 1'b1;
         end
         default: begin
            pcWrite            = 1'b0;
            harzardIF_ID_Write = 1'b1;
            IF_flush           = 1'b0;
            ID_EX_bubble       = 1'b1;
         end
      endcase
   end

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic stall_event;
   logic flush_event;

   // Decide which RUN cycles are counted as stalls or flushes.
   always_comb begin
      stall_event = (state_reg == RUN) && (load_use || memBusy);
      flush_event = (state_reg == RUN) && IF_flush;
   end

   // Saturating performance counters. They hold at all-ones rather than
   // wrapping back to zero.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         stallCount <= 32'd0;
         flushCount <= 32'd0;
      end else begin
         if (stall_event && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
         end
         if (flush_event && (flushCount != 32'hFFFF_FFFF)) begin
            flushCount <= flushCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Directed scenarios followed by a randomized run. Every output is checked
// against a behavioural model of the controller rules on every cycle.
// Define PIPE_CTRL_PERF_CNT_EN to build and check the counter variant.
module tb_pipeline_hazard_controller;

   localparam int unsigned WARM = 2;

   logic        clk;
   logic        rstN;
   logic        startProcess;
   logic        haltReq;
   logic        memBusy;
   logic [4:0]  ID_rs1;
   logic [4:0]  ID_rs2;
   logic        ID_useRs1;
   logic        ID_useRs2;
   logic [4:0]  EX_rd;
   logic        EX_memRead;
   logic        EX_branchTaken;
   logic        pcWrite;
   logic        harzardIF_ID_Write;
   logic        IF_flush;
   logic        ID_EX_bubble;
   logic        running;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stallCount;
   logic [31:0] flushCount;
`endif

   pipeline_hazard_controller #(.WARMUP_CYCLES(WARM)) dut (
      .clk                (clk),
      .rstN               (rstN),
      .startProcess       (startProcess),
      .haltReq            (haltReq),
      .memBusy            (memBusy),
      .ID_rs1             (ID_rs1),
      .ID_rs2             (ID_rs2),
      .ID_useRs1          (ID_useRs1),
      .ID_useRs2          (ID_useRs2),
      .EX_rd              (EX_rd),
      .EX_memRead         (EX_memRead),
      .EX_branchTaken     (EX_branchTaken),
      .pcWrite            (pcWrite),
      .harzardIF_ID_Write (harzardIF_ID_Write),
      .IF_flush           (IF_flush),
      .ID_EX_bubble       (ID_EX_bubble),
      .running            (running)
`ifdef PIPE_CTRL_PERF_CNT_EN
      ,
      .stallCount         (stallCount),
      .flushCount         (flushCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the mode (0 idle, 1 warmup, 2 run, 3 halted), the number of
   // warmup cycles still to go, and the expected counter values.
   int          m_mode;
   int          m_left;
   int unsigned m_stall;
   int unsigned m_flush;
   int          n_checks;
   int          n_fail;
   int          cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_load_use();
      bit hit1;
      bit hit2;
      hit1 = ID_useRs1 && (ID_rs1 == EX_rd);
      hit2 = ID_useRs2 && (ID_rs2 == EX_rd);
      return EX_memRead && (EX_rd != 0) && (hit1 || hit2);
   endfunction

   // Expected outputs, packed as {pcWrite, IF/ID write, flush, bubble}.
   function automatic logic [3:0] model_outs();
      if (m_mode == 3) return 4'b0001;
      if (m_mode != 2) return 4'b0101;
      if (memBusy) return 4'b0000;
      if (EX_branchTaken) return 4'b1111;
      if (model_load_use()) return 4'b0001;
      return 4'b1100;
   endfunction

   function automatic int unsigned sat_inc(input int unsigned v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_left  = 0;
      m_stall = 0;
      m_flush = 0;
   endtask

   // Advance the model by one clock edge, using the current inputs.
   task automatic model_step();
      logic [3:0] o;
      o = model_outs();
      case (m_mode)
         0: if (startProcess) begin
               m_mode = 1;
               m_left = WARM;
            end
         1: begin
               m_left--;
               if (m_left == 0) m_mode = 2;
            end
         2: begin
               if (memBusy || model_load_use()) m_stall = sat_inc(m_stall);
               if (o[1]) m_flush = sat_inc(m_flush);
               if (haltReq && !memBusy) m_mode = 3;
            end
         default: ;
      endcase
   endtask

   // One cycle: inputs were set at the falling edge. Let them settle,
   // compare every output with the model, then move through the rising edge.
   task automatic tick(input string tag);
      logic [3:0] e;
      #1;
      e = model_outs();
      $display("cyc %0d %s mode=%0d pc=%b ifid=%b fl=%b bub=%b run=%b", cyc, tag, m_mode,
               pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble, running);
      chk({tag, "_outs"}, {28'd0, pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble}, {28'd0, e});
      chk({tag, "_running"}, {31'd0, running}, {31'd0, m_mode == 2});
`ifdef PIPE_CTRL_PERF_CNT_EN
      chk({tag, "_stallCount"}, stallCount, m_stall);
      chk({tag, "_flushCount"}, flushCount, m_flush);
`endif
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_inputs();
      startProcess   = 0;
      haltReq        = 0;
      memBusy        = 0;
      ID_rs1         = 0;
      ID_rs2         = 0;
      ID_useRs1      = 0;
      ID_useRs2      = 0;
      EX_rd          = 0;
      EX_memRead     = 0;
      EX_branchTaken = 0;
   endtask

   // Assert reset in the middle of a cycle. The outputs must switch to
   // their reset values at once, without waiting for a clock edge.
   task automatic async_reset(input string tag);
      #3;
      rstN = 0;
      #1;
      chk({tag, "_rst_outs"}, {28'd0, pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble}, 32'h5);
      chk({tag, "_rst_running"}, {31'd0, running}, 32'd0);
      model_reset();
      @(negedge clk);
      rstN = 1;
      cyc = 0;
   endtask

   // From IDLE, pulse start and step through warmup into RUN.
   task automatic go_run();
      startProcess = 1;
      tick("start");
      startProcess = 0;
      for (int i = 0; i < WARM; i++) tick("warm");
   endtask

   int unsigned base_stall;
   int unsigned base_flush;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      clear_inputs();
      model_reset();
      rstN = 0;
      #2;
      chk("por_outs", {28'd0, pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble}, 32'h5);
      chk("por_running", {31'd0, running}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1;

      // Startup: start is pulsed at cycle 3, warmup lasts two cycles and
      // RUN begins at cycle 6.
      for (int i = 0; i < 3; i++) tick("idle");
      go_run();
      #1;
      chk("c6_running", {31'd0, running}, 32'd1);
      chk("c6_pcWrite", {31'd0, pcWrite}, 32'd1);
      tick("run0");

      // A load followed by a dependent read of x5 through rs2 stalls for
      // exactly one cycle.
      EX_memRead = 1; EX_rd = 5; ID_rs2 = 5; ID_useRs2 = 1;
      #1;
      chk("lu_stall", {28'd0, pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble}, 32'h1);
      tick("loaduse");
      EX_memRead = 0;
      #1;
      chk("lu_release", {28'd0, pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble}, 32'hC);
      tick("lu_after");

      // The same pattern against x0 must not stall.
      EX_memRead = 1; EX_rd = 0; ID_rs2 = 0; ID_useRs2 = 1;
      #1;
      chk("x0_nostall", {31'd0, pcWrite}, 32'd1);
      tick("x0");
      clear_inputs();

      // A branch together with a load-use hazard on x7 flushes only.
      EX_branchTaken = 1; EX_memRead = 1; EX_rd = 7; ID_rs1 = 7; ID_useRs1 = 1;
      #1;
      chk("br_lu", {28'd0, pcWrite, harzardIF_ID_Write, IF_flush, ID_EX_bubble}, 32'hF);
      tick("br_lu");
      clear_inputs();

      // memBusy for three cycles with the branch held: the pipeline freezes,
      // and the deferred flush is issued in the fourth cycle.
      base_stall = m_stall;
      base_flush = m_flush;
      EX_branchTaken = 1; memBusy = 1;
      for (int i = 0; i < 3; i++) tick("busy");
      memBusy = 0;
      #1;
      chk("deferred_flush", {31'd0, IF_flush}, 32'd1);
      tick("busy_end");
      EX_branchTaken = 0;
      #1;
`ifdef PIPE_CTRL_PERF_CNT_EN
      chk("busy_stallCount", stallCount, base_stall + 3);
      chk("busy_flushCount", flushCount, base_flush + 1);
`endif
      tick("post_busy");

      // A halt held during memBusy waits for the stall to clear. A halt with
      // a branch flushes in that cycle and then halts.
      haltReq = 1; memBusy = 1;
      tick("halt_busy");
      memBusy = 0; EX_branchTaken = 1;
      #1;
      chk("halt_flush", {31'd0, IF_flush}, 32'd1);
      tick("halt_br");
      clear_inputs();
      startProcess = 1;
      for (int i = 0; i < 3; i++) tick("halted");
      #1;
      chk("halted_pc", {31'd0, pcWrite}, 32'd0);
      async_reset("halted");
      clear_inputs();
      tick("after_rst");

      // Reset in the middle of warmup restarts the whole warmup period.
      startProcess = 1;
      tick("start2");
      startProcess = 0;
      async_reset("midwarm");
      tick("idle2");
      go_run();
      tick("run2");

      // Randomized traffic. Register numbers are drawn from a small range so
      // that hazards occur often. Occasional resets and halts are included.
      for (int n = 0; n < 600; n++) begin
         startProcess   = ($urandom_range(0, 3) == 0);
         haltReq        = ($urandom_range(0, 39) == 0);
         memBusy        = ($urandom_range(0, 3) == 0);
         EX_branchTaken = ($urandom_range(0, 4) == 0);
         EX_memRead     = $urandom_range(0, 1) == 1;
         EX_rd          = 5'($urandom_range(0, 3));
         ID_rs1         = 5'($urandom_range(0, 3));
         ID_rs2         = 5'($urandom_range(0, 3));
         ID_useRs1      = $urandom_range(0, 1) == 1;
         ID_useRs2      = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 99) == 0 || (m_mode == 3 && $urandom_range(0, 9) == 0)) begin
            async_reset("rand");
         end
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL use one clock; reset SHALL be asynchronous and active-low, with ports named clk and rstN.
REQ-002 The block SHALL have parameter WARMUP_CYCLES, default 2, giving the number of cycles spent in WARMUP; the legal range SHALL be 1..7.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- startProcess  in  1  leave IDLE
- haltReq  in  1  stop fetching permanently (ecall/ebreak in EX)
- memBusy  in  1  data memory not ready; freeze the whole pipeline
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID
- ID_useRs1, ID_useRs2  in  1 each  the ID instruction reads rs1 / rs2
- EX_rd  in  5  destination register of the instruction in EX
- EX_memRead  in  1  the EX instruction is a load
- EX_branchTaken  in  1  a taken branch/jump is resolved in EX
- pcWrite  out  1  PC update enable
- harzardIF_ID_Write  out  1  IF/ID register load enable
- IF_flush  out  1  replace IF/ID contents with a NOP
- ID_EX_bubble  out  1  zero the ID/EX control fields
- running  out  1  the FSM is in RUN

Function
REQ-004 The FSM SHALL have four registered states: IDLE, WARMUP, RUN and HALTED.
REQ-005 FSM transitions:
- IDLE to WARMUP when startProcess=1.
- WARMUP to RUN after exactly WARMUP_CYCLES cycles; the counter clears on entry and the FSM exits when counter==WARMUP_CYCLES-1.
- RUN to HALTED when haltReq=1 and memBusy=0.
- HALTED is left only by reset.
REQ-006 startProcess SHALL be ignored outside IDLE.
REQ-007 Outputs SHALL be combinational from the registered state and the current inputs.
REQ-008 In IDLE and WARMUP the outputs SHALL be: pcWrite=0, harzardIF_ID_Write=1, IF_flush=0, ID_EX_bubble=1.
REQ-009 In HALTED the outputs SHALL be: pcWrite=0, harzardIF_ID_Write=0, IF_flush=0, ID_EX_bubble=1.
REQ-010 loadUse SHALL be asserted exactly when EX_memRead=1, EX_rd!=0, and either (ID_useRs1=1 and ID_rs1==EX_rd) or (ID_useRs2=1 and ID_rs2==EX_rd).
REQ-011 In RUN the outputs SHALL follow this strict priority:
- memBusy: pcWrite=0, harzardIF_ID_Write=0, IF_flush=0, ID_EX_bubble=0 (hold everything).
- else EX_branchTaken: pcWrite=1, harzardIF_ID_Write=1, IF_flush=1, ID_EX_bubble=1.
- else loadUse: pcWrite=0, harzardIF_ID_Write=0, IF_flush=0, ID_EX_bubble=1.
- else: pcWrite=1, harzardIF_ID_Write=1, IF_flush=0, ID_EX_bubble=0.
REQ-012 A branch and a load-use hazard in the same cycle SHALL produce the flush response only; the wrong-path instruction is never stalled.
REQ-013 A branch during memBusy SHALL be deferred and take effect in the first cycle after memBusy falls, provided EX_branchTaken is still 1 then.
REQ-014 haltReq together with EX_branchTaken in RUN with memBusy=0 SHALL apply that cycle's flush outputs and then enter HALTED.
REQ-015 A load-use stall SHALL last exactly one cycle when EX advances normally, because the bubble clears EX_memRead.
REQ-016 running SHALL equal 1 only in RUN.

Reset
REQ-017 Asserting rstN=0 SHALL immediately force IDLE and clear the warmup counter, in any state including mid-warmup and HALTED.
REQ-018 The output values during reset SHALL be pcWrite=0, harzardIF_ID_Write=1, IF_flush=0, ID_EX_bubble=1, running=0.
REQ-019 The first state update after rstN rises SHALL occur on the next rising edge of clk.

Configuration
REQ-020 With PIPE_CTRL_PERF_CNT_EN defined, the block SHALL add 32-bit outputs stallCount and flushCount.
- Both counters reset to 0 and saturate at 0xFFFFFFFF.
- stallCount increments on every RUN cycle with loadUse=1 or memBusy=1.
- flushCount increments on every RUN cycle where IF_flush=1.
REQ-021 Without PIPE_CTRL_PERF_CNT_EN, neither port nor any counter logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then startProcess pulsed one cycle at cycle 3 -> WARMUP in cycles 4-5, running=1 from cycle 6, pcWrite=0 until cycle 6.
- RUN with EX_memRead=1, EX_rd=5, ID_rs2=5, ID_useRs2=1 -> exactly one cycle of pcWrite=0, harzardIF_ID_Write=0, ID_EX_bubble=1.
- The same as above but EX_rd=0 -> no stall.
- RUN with EX_branchTaken=1 and a simultaneous load-use on x7 -> IF_flush=1, pcWrite=1, harzardIF_ID_Write=1 only.
- memBusy=1 for 3 cycles with EX_branchTaken=1 held -> all enables 0 for 3 cycles, then IF_flush=1 in cycle 4; with the macro, stallCount=3 and flushCount=1.
- haltReq=1 in RUN, then rstN pulsed low mid-HALTED -> HALTED with pcWrite=0 sticky, then IDLE asynchronously with running=0.
